// File: rtl/cpu_pkg.sv
// Shared types and constants for the control unit: opcodes, FSM states,
// ALU operation codes and the opcode-to-state decode helper.
package cpu_pkg;

  localparam int PC_WIDTH_DEF  = 7;
  localparam int D_ADDR_WIDTH  = 8;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_NONE = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // Maps an opcode field to the execute state that follows Decode.
  // Illegal opcodes (6..15) fall through to NoOp.
  function automatic state_t decode_state(input logic [3:0] op);
    state_t st;
    case (op)
      OP_NOOP:  st = S_NOOP;
      OP_STORE: st = S_STORE;
      OP_LOAD:  st = S_LOADA;
      OP_ADD:   st = S_ADD;
      OP_SUB:   st = S_SUB;
      OP_HALT:  st = S_HALT;
      default:  st = S_NOOP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/control_unit_program_counter.sv
// Program counter: PC_WIDTH-bit wrapping up-counter with asynchronous
// active-low clear and an increment enable.
module program_counter
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_inc,
  output logic [PC_WIDTH-1:0] o_pc
);

  logic [PC_WIDTH-1:0] r_pc;

  // Count register; natural binary overflow gives the modulo-2**PC_WIDTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_WIDTH'(1);
    end else begin
      r_pc <= r_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/control_unit.sv
// Control unit: fetch/decode/execute sequencer for the 16-bit datapath.
// Owns the IR and the FSM; the PC lives in the program_counter sub-module.
// All outputs are a Moore decode of the state and IR registers.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [15:0]             instr_in,
  output logic [PC_WIDTH-1:0]     pc_addr,
  output logic                    ir_ld,
  output logic [D_ADDR_WIDTH-1:0] d_addr,
  output logic                    d_wr,
  output logic                    rf_s,
  output logic [3:0]              rf_w_addr,
  output logic                    rf_w_en,
  output logic [3:0]              rf_ra_addr,
  output logic [3:0]              rf_rb_addr,
  output logic [1:0]              alu_op,
  output logic                    halted,
  output logic [3:0]              state_dbg
);

  state_t              r_state;
  state_t              w_state_next;
  logic [15:0]         r_ir;
  logic [PC_WIDTH-1:0] w_pc;
  logic                w_pc_inc;
  logic [3:0]          w_opcode;

  assign w_opcode = r_ir[15:12];
  assign w_pc_inc = (r_state == S_FETCH);

  program_counter #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_pc_inc),
    .o_pc  (w_pc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Instruction register: captures instr_in only at the end of Fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= 16'h0000;
    end else if (r_state == S_FETCH) begin
      r_ir <= instr_in;
    end else begin
      r_ir <= r_ir;
    end
  end

  // Next-state logic; Halt is terminal until reset.
  always_comb begin
    w_state_next = S_INIT;
    case (r_state)
      S_INIT:   w_state_next = S_FETCH;
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: w_state_next = decode_state(w_opcode);
      S_NOOP:   w_state_next = S_FETCH;
      S_STORE:  w_state_next = S_FETCH;
      S_LOADA:  w_state_next = S_LOADB;
      S_LOADB:  w_state_next = S_FETCH;
      S_ADD:    w_state_next = S_FETCH;
      S_SUB:    w_state_next = S_FETCH;
      S_HALT:   w_state_next = S_HALT;
      // Unreachable encodings recover through Init.
      default:  w_state_next = S_INIT;
    endcase
  end

  // Moore output decode from state and IR fields.
  always_comb begin
    ir_ld      = 1'b0;
    d_addr     = 8'h00;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = 4'h0;
    rf_w_en    = 1'b0;
    rf_ra_addr = 4'h0;
    rf_rb_addr = 4'h0;
    alu_op     = ALU_NONE;
    halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_ld = 1'b1;
      end
      S_STORE: begin
        d_addr     = r_ir[7:0];
        rf_ra_addr = r_ir[11:8];
        d_wr       = 1'b1;
      end
      // LoadA waits out the synchronous RAM read; LoadB commits the write.
      S_LOADA: begin
        d_addr    = r_ir[11:4];
        rf_s      = 1'b1;
        rf_w_addr = r_ir[3:0];
      end
      S_LOADB: begin
        d_addr    = r_ir[11:4];
        rf_s      = 1'b1;
        rf_w_addr = r_ir[3:0];
        rf_w_en   = 1'b1;
      end
      S_ADD: begin
        rf_ra_addr = r_ir[11:8];
        rf_rb_addr = r_ir[7:4];
        rf_w_addr  = r_ir[3:0];
        alu_op     = ALU_ADD;
        rf_w_en    = 1'b1;
      end
      S_SUB: begin
        rf_ra_addr = r_ir[11:8];
        rf_rb_addr = r_ir[7:4];
        rf_w_addr  = r_ir[3:0];
        alu_op     = ALU_SUB;
        rf_w_en    = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        ir_ld = 1'b0;
      end
    endcase
  end

  assign pc_addr   = w_pc;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr_in;
  logic [6:0]  pc_addr;
  logic        ir_ld;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic        rf_s;
  logic [3:0]  rf_w_addr;
  logic        rf_w_en;
  logic [3:0]  rf_ra_addr;
  logic [3:0]  rf_rb_addr;
  logic [1:0]  alu_op;
  logic        halted;
  logic [3:0]  state_dbg;

  int n_checks;
  int n_fail;

  control_unit #(.PC_WIDTH(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_in   (instr_in),
    .pc_addr    (pc_addr),
    .ir_ld      (ir_ld),
    .d_addr     (d_addr),
    .d_wr       (d_wr),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_w_en    (rf_w_en),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .alu_op     (alu_op),
    .halted     (halted),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the run must end on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed still running, required done");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks every output against one expected vector.
  task automatic expect_outs(input string tag, input logic [3:0] st, input logic [6:0] pc,
                             input logic ld, input logic [7:0] da, input logic dw,
                             input logic s, input logic [3:0] wa, input logic we,
                             input logic [3:0] ra, input logic [3:0] rb,
                             input logic [1:0] op, input logic h);
    check_eq({tag, ".state"},  {28'd0, state_dbg}, {28'd0, st});
    check_eq({tag, ".pc"},     {25'd0, pc_addr},   {25'd0, pc});
    check_eq({tag, ".ir_ld"},  {31'd0, ir_ld},     {31'd0, ld});
    check_eq({tag, ".d_addr"}, {24'd0, d_addr},    {24'd0, da});
    check_eq({tag, ".d_wr"},   {31'd0, d_wr},      {31'd0, dw});
    check_eq({tag, ".rf_s"},   {31'd0, rf_s},      {31'd0, s});
    check_eq({tag, ".w_addr"}, {28'd0, rf_w_addr}, {28'd0, wa});
    check_eq({tag, ".w_en"},   {31'd0, rf_w_en},   {31'd0, we});
    check_eq({tag, ".ra"},     {28'd0, rf_ra_addr},{28'd0, ra});
    check_eq({tag, ".rb"},     {28'd0, rf_rb_addr},{28'd0, rb});
    check_eq({tag, ".alu"},    {30'd0, alu_op},    {30'd0, op});
    check_eq({tag, ".halted"}, {31'd0, halted},    {31'd0, h});
  endtask

  // Advance one clock and sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    instr_in = 16'h21B5;
    #12;
    expect_outs("reset", 4'd0, 7'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);

    // 1. LOAD 21B5
    @(negedge clk);
    rst_n = 1'b1;
    expect_outs("init", 4'd0, 7'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    step();
    expect_outs("ld_fetch", 4'd1, 7'd0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    step();
    expect_outs("ld_decode", 4'd2, 7'd1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    step();
    expect_outs("ld_a", 4'd4, 7'd1, 1'b0, 8'h1B, 1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    step();
    expect_outs("ld_b", 4'd5, 7'd1, 1'b0, 8'h1B, 1'b0, 1'b1, 4'h5, 1'b1, 4'h0, 4'h0, 2'b00, 1'b0);
    step();
    expect_outs("ld_done", 4'd1, 7'd1, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);

    // 2. ADD 3123 then SUB 4123
    instr_in = 16'h3123;
    step();
    expect_outs("add_decode", 4'd2, 7'd2, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    step();
    expect_outs("add_exec", 4'd7, 7'd2, 1'b0, 8'h00, 1'b0, 1'b0, 4'h3, 1'b1, 4'h1, 4'h2, 2'b01, 1'b0);
    step();
    expect_outs("add_done", 4'd1, 7'd2, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    instr_in = 16'h4123;
    step();
    step();
    expect_outs("sub_exec", 4'd8, 7'd3, 1'b0, 8'h00, 1'b0, 1'b0, 4'h3, 1'b1, 4'h1, 4'h2, 2'b10, 1'b0);
    step();
    expect_outs("sub_done", 4'd1, 7'd3, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);

    // 3. STORE 1A40
    instr_in = 16'h1A40;
    step();
    step();
    expect_outs("st_exec", 4'd6, 7'd4, 1'b0, 8'h40, 1'b1, 1'b0, 4'h0, 1'b0, 4'hA, 4'h0, 2'b00, 1'b0);
    step();
    expect_outs("st_done", 4'd1, 7'd4, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);

    // 5. Asynchronous reset in the middle of an Add cycle
    instr_in = 16'h3123;
    step();
    step();
    expect_outs("add2_exec", 4'd7, 7'd5, 1'b0, 8'h00, 1'b0, 1'b0, 4'h3, 1'b1, 4'h1, 4'h2, 2'b01, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_outs("async_rst", 4'd0, 7'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6. NOOP stream up to PC=126, then illegal F000 across the wrap
    instr_in = 16'h0000;
    step();
    for (int k = 0; k < 126; k++) begin
      step();
      step();
      step();
    end
    instr_in = 16'hF000;
    expect_outs("wrap_f126", 4'd1, 7'd126, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    step();
    expect_outs("ill_decode", 4'd2, 7'd127, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    step();
    expect_outs("ill_noop", 4'd3, 7'd127, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    instr_in = 16'h0000;
    step();
    expect_outs("wrap_f127", 4'd1, 7'd127, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    step();
    step();
    step();
    expect_outs("wrap_f0", 4'd1, 7'd0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);

    // 4. HALT 5000: frozen for 22 cycles, then reset pulse
    instr_in = 16'h5000;
    step();
    step();
    for (int k = 0; k < 22; k++) begin
      expect_outs("halt", 4'd9, 7'd1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    expect_outs("halt_rst", 4'd0, 7'd0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expect_outs("post_rst", 4'd1, 7'd0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
